decode_pipe: RTL
================

# decode_pipe

- Parametrised, pipelined instruction decode stage for the bf8b core.
- Accepts raw instruction words over a valid/ready handshake and splits them into opcode, register, address and immediate fields, with an illegal-opcode flag.
- Presents decoded fields to execute over a second valid/ready handshake.
- A two-entry skid buffer sustains one instruction per cycle under backpressure; a flush input discards in-flight instructions on branches.

## Interface
Parameters:
- OP_W, 4, opcode width
- REG_W, 4, register-index width; INST_W = OP_W + 3*REG_W, ADDR_W = 2*REG_W
- DATA_W, 8, immediate width; DATA_W <= ADDR_W
- IMM_SHORT_W, 4, short-immediate width, sign-extended to DATA_W; IMM_SHORT_W <= REG_W
- OP_LODI, 4'b0001, opcode whose immediate is the full low DATA_W bits
- ILLEGAL_MASK, 16'h0000, bit k set = opcode k is illegal; width 2**OP_W
- CNT_W, 16, delivered-instruction counter width

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- flush  in  1  discard all held instructions
- in_valid  in  1  inst is valid
- in_ready  out  1  stage can accept
- inst  in  INST_W  raw instruction word
- out_valid  out  1  decoded fields valid
- out_ready  in  1  execute accepts
- op  out  OP_W  inst[INST_W-1 -: OP_W]
- reg0  out  REG_W  inst[3*REG_W-1 -: REG_W]
- reg1  out  REG_W  inst[2*REG_W-1 -: REG_W]
- reg2  out  REG_W  inst[REG_W-1:0]
- addr  out  ADDR_W  inst[ADDR_W-1:0]
- imm  out  DATA_W  decoded immediate
- illegal  out  1  ILLEGAL_MASK[op]
- count  out  CNT_W  instructions delivered since reset

## Operation
- Accept on in_valid && in_ready; deliver on out_valid && out_ready.
- Fields are decoded from the incoming word before storage; both buffer entries hold decoded fields.
- imm is selected from the opcode of the same instruction:
  - op == OP_LODI: inst[DATA_W-1:0].
  - Otherwise: sign-extend inst[IMM_SHORT_W-1:0] to DATA_W.
- Storage:
  - Output register (main): drives the outputs.
  - Skid register: catches one word accepted while main is stalled.
- States by occupancy:
  - EMPTY (0 valid): accept -> ONE.
  - ONE (main valid):
    - Accept with deliver -> ONE; main replaced.
    - Accept with no deliver -> TWO; word to skid.
    - Deliver with no accept -> EMPTY.
  - TWO (both valid): in_ready = 0. Deliver -> ONE; skid moves to main.
- in_ready = !rst && !skid_valid. It does not depend on out_ready combinationally.
- count increments by 1 per delivery and wraps to 0 from 2**CNT_W-1. It is not cleared by flush.

## Timing
- Latency: word accepted at edge N appears on the outputs with out_valid = 1 after edge N (cycle N+1).
- Throughput: 1 word/cycle while out_ready = 1.
- Reset values (rst high at an edge):
  - out_valid = 0, skid_valid = 0, count = 0, illegal = 0.
  - op, reg0, reg1, reg2, addr, imm = 0.
  - in_ready = 0 while rst is high.
- Flush high at an edge:
  - Clears out_valid and skid_valid; the next cycle is EMPTY.
  - Any handshake on the input side in the same cycle is dropped.
  - A delivery in the same cycle counts; execute saw it.
  - Data fields hold their values.
- rst and flush together: rst wins.
- rst mid-stream: all held words are lost; no partial output.
- Decoded fields and illegal are stable while out_valid && !out_ready.
- When out_valid = 0, field values are don't-care except after reset.

## Structure
- Package bf8b_pkg holds:
  - opcode localparams, including OP_LODI;
  - the default field widths;
  - a packed struct decoded_t {op, reg0, reg1, reg2, addr, imm, illegal}.
- Sub-module decode_fields: combinational inst -> decoded_t. It is instantiated once, at the input.
- decode_pipe holds the two decoded_t registers, the valid bits and the counter.

## Test plan
- Streaming: reset, out_ready = 1, send 16'h1A5F (LODI) then 16'h2347 on consecutive cycles.
  - Required: outputs one cycle later, op = 1, imm = 8'h5F; then op = 2, reg0 = 3, reg1 = 4, reg2 = 7, imm = 8'h07.
  - Required: count = 2.
- Sign extension: send 16'h300C -> imm = 8'hFC, addr = 8'h0C.
- Backpressure:
  - Hold out_ready = 0 and offer 3 words back-to-back.
  - Required: in_ready drops after the 2nd accept; the 3rd word waits on the input side.
  - Release out_ready: delivery order 1, 2, 3 with no loss or duplication.
- Flush:
  - In state TWO, pulse flush with in_valid = 1.
  - Required: out_valid = 0 next cycle and the input word is not accepted; count unchanged.
  - Required: the next word decodes normally.
- Illegal and wrap:
  - With ILLEGAL_MASK = 16'h8000, send op 4'hF -> illegal = 1.
  - With CNT_W = 3, deliver 9 words -> count = 1.
- Reset mid-stream: assert rst while in state TWO.
  - Required: out_valid = 0 and all fields 0 after the edge.
  - Required: in_ready = 0 during rst and 1 the cycle after.

Source files
------------

// File: rtl/bf8b_pkg.sv
// -----------------------------------------------------------------------------
// bf8b_pkg
// Shared definitions for the bf8b core decode stage:
//   - default field widths of the instruction word
//   - opcode constants (OP_LODI carries a full-width immediate)
//   - occupancy state encoding for the decode output buffer
//   - decoded_t: decoded instruction fields at the default widths
// -----------------------------------------------------------------------------
package bf8b_pkg;

    // Default field widths
    localparam int BF8B_OP_W        = 4;
    localparam int BF8B_REG_W       = 4;
    localparam int BF8B_DATA_W      = 8;
    localparam int BF8B_IMM_SHORT_W = 4;
    localparam int BF8B_CNT_W       = 16;
    localparam int BF8B_INST_W      = BF8B_OP_W + 3 * BF8B_REG_W;
    localparam int BF8B_ADDR_W      = 2 * BF8B_REG_W;

    // Opcodes
    localparam logic [BF8B_OP_W-1:0] OP_NOP  = 4'b0000;
    localparam logic [BF8B_OP_W-1:0] OP_LODI = 4'b0001;
    localparam logic [BF8B_OP_W-1:0] OP_ADD  = 4'b0010;
    localparam logic [BF8B_OP_W-1:0] OP_SUB  = 4'b0011;

    // No opcode is illegal by default
    localparam logic [2**BF8B_OP_W-1:0] BF8B_ILLEGAL_MASK = 16'h0000;

    // Buffer occupancy. Bit 0 = main entry valid, bit 1 = skid entry valid,
    // so both valid flags come straight from state register bits.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_TWO   = 2'b11
    } occ_state_e;

    // Decoded instruction at the default widths
    typedef struct packed {
        logic [BF8B_OP_W-1:0]   op;
        logic [BF8B_REG_W-1:0]  reg0;
        logic [BF8B_REG_W-1:0]  reg1;
        logic [BF8B_REG_W-1:0]  reg2;
        logic [BF8B_ADDR_W-1:0] addr;
        logic [BF8B_DATA_W-1:0] imm;
        logic                   illegal;
    } decoded_t;

endpackage : bf8b_pkg

// File: rtl/decode_fields.sv
// -----------------------------------------------------------------------------
// decode_fields
// Purely combinational split of a raw instruction word into decoded fields.
// Ports:
//   inst  in   INST_W  raw instruction word
//   dec   out  DEC_W   packed {op, reg0, reg1, reg2, addr, imm, illegal}
// The immediate is the low DATA_W bits for OP_LODI, otherwise the low
// IMM_SHORT_W bits sign-extended to DATA_W.
// -----------------------------------------------------------------------------
module decode_fields
    import bf8b_pkg::*;
#(
    parameter int                    OP_W         = BF8B_OP_W,
    parameter int                    REG_W        = BF8B_REG_W,
    parameter int                    DATA_W       = BF8B_DATA_W,
    parameter int                    IMM_SHORT_W  = BF8B_IMM_SHORT_W,
    parameter logic [OP_W-1:0]       OP_LODI      = bf8b_pkg::OP_LODI,
    parameter logic [2**OP_W-1:0]    ILLEGAL_MASK = BF8B_ILLEGAL_MASK,
    localparam int                   INST_W       = OP_W + 3 * REG_W,
    localparam int                   ADDR_W       = 2 * REG_W,
    localparam int                   DEC_W        = OP_W + 3 * REG_W + ADDR_W + DATA_W + 1
) (
    input  logic [INST_W-1:0] inst,
    output logic [DEC_W-1:0]  dec
);

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  reg0;
        logic [REG_W-1:0]  reg1;
        logic [REG_W-1:0]  reg2;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] imm;
        logic              illegal;
    } dec_t;

    logic [OP_W-1:0] op_s;
    dec_t            dec_s;

    assign op_s = inst[INST_W-1 -: OP_W];

    // Field extraction and immediate selection
    always_comb begin
        dec_s         = {DEC_W{1'b0}};
        dec_s.op      = op_s;
        dec_s.reg0    = inst[3*REG_W-1 -: REG_W];
        dec_s.reg1    = inst[2*REG_W-1 -: REG_W];
        dec_s.reg2    = inst[REG_W-1:0];
        dec_s.addr    = inst[ADDR_W-1:0];
        dec_s.illegal = ILLEGAL_MASK[op_s];
        if (op_s == OP_LODI) begin
            dec_s.imm = inst[DATA_W-1:0];
        end else begin
            dec_s.imm = {{(DATA_W-IMM_SHORT_W){inst[IMM_SHORT_W-1]}},
                         inst[IMM_SHORT_W-1:0]};
        end
    end

    assign dec = dec_s;

endmodule : decode_fields

// File: rtl/decode_pipe.sv
// -----------------------------------------------------------------------------
// decode_pipe
// Pipelined decode stage for the bf8b core. Raw words arrive on a valid/ready
// handshake, are decoded before storage, and are held in a two-entry buffer
// (main + skid) that drives execute over a second valid/ready handshake.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   flush               drop all held instructions (branch taken)
//   in_valid/in_ready   input handshake; inst is the raw word
//   out_valid/out_ready output handshake
//   op, reg0, reg1, reg2, addr, imm, illegal   decoded fields of main entry
//   count               instructions delivered since reset (wraps)
// in_ready depends only on rst and the skid flag, never on out_ready.
// -----------------------------------------------------------------------------
module decode_pipe
    import bf8b_pkg::*;
#(
    parameter int                 OP_W         = BF8B_OP_W,
    parameter int                 REG_W        = BF8B_REG_W,
    parameter int                 DATA_W       = BF8B_DATA_W,
    parameter int                 IMM_SHORT_W  = BF8B_IMM_SHORT_W,
    parameter logic [OP_W-1:0]    OP_LODI      = bf8b_pkg::OP_LODI,
    parameter logic [2**OP_W-1:0] ILLEGAL_MASK = BF8B_ILLEGAL_MASK,
    parameter int                 CNT_W        = BF8B_CNT_W,
    localparam int                INST_W       = OP_W + 3 * REG_W,
    localparam int                ADDR_W       = 2 * REG_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OP_W-1:0]   op,
    output logic [REG_W-1:0]  reg0,
    output logic [REG_W-1:0]  reg1,
    output logic [REG_W-1:0]  reg2,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] imm,
    output logic              illegal,
    output logic [CNT_W-1:0]  count
);

    localparam int DEC_W = OP_W + 3 * REG_W + ADDR_W + DATA_W + 1;

    typedef struct packed {
        logic [OP_W-1:0]   op;
        logic [REG_W-1:0]  reg0;
        logic [REG_W-1:0]  reg1;
        logic [REG_W-1:0]  reg2;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] imm;
        logic              illegal;
    } dec_t;

    occ_state_e       state_r;
    occ_state_e       state_nx_s;
    dec_t             main_r;
    dec_t             skid_r;
    dec_t             dec_in_s;
    logic [DEC_W-1:0] dec_in_flat_s;
    logic [CNT_W-1:0] count_r;
    logic             accept_s;
    logic             deliver_s;
    logic             load_main_in_s;
    logic             load_main_skid_s;
    logic             load_skid_s;

    decode_fields #(
        .OP_W         (OP_W),
        .REG_W        (REG_W),
        .DATA_W       (DATA_W),
        .IMM_SHORT_W  (IMM_SHORT_W),
        .OP_LODI      (OP_LODI),
        .ILLEGAL_MASK (ILLEGAL_MASK)
    ) u_decode_fields (
        .inst (inst),
        .dec  (dec_in_flat_s)
    );

    assign dec_in_s = dec_in_flat_s;

    // Valid flags are the state bits themselves (see occ_state_e encoding)
    assign out_valid = state_r[0];
    assign in_ready  = !rst && !state_r[1];
    assign accept_s  = in_valid && in_ready;
    assign deliver_s = state_r[0] && out_ready;

    // Occupancy state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_EMPTY;
        end else begin
            state_r <= state_nx_s;
        end
    end

    // Next occupancy and which entry loads what; flush empties the buffer
    // and drops any input handshake of the same cycle
    always_comb begin
        state_nx_s       = state_r;
        load_main_in_s   = 1'b0;
        load_main_skid_s = 1'b0;
        load_skid_s      = 1'b0;
        if (flush) begin
            state_nx_s = ST_EMPTY;
        end else begin
            case (state_r)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_nx_s     = ST_ONE;
                        load_main_in_s = 1'b1;
                    end else begin
                        state_nx_s = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && deliver_s) begin
                        state_nx_s     = ST_ONE;
                        load_main_in_s = 1'b1;
                    end else if (accept_s) begin
                        state_nx_s  = ST_TWO;
                        load_skid_s = 1'b1;
                    end else if (deliver_s) begin
                        state_nx_s = ST_EMPTY;
                    end else begin
                        state_nx_s = ST_ONE;
                    end
                end
                ST_TWO: begin
                    if (deliver_s) begin
                        state_nx_s       = ST_ONE;
                        load_main_skid_s = 1'b1;
                    end else begin
                        state_nx_s = ST_TWO;
                    end
                end
                default: begin
                    state_nx_s = ST_EMPTY;
                end
            endcase
        end
    end

    // Decoded-field storage; fields hold whenever no load is requested
    always_ff @(posedge clk) begin
        if (rst) begin
            main_r <= {DEC_W{1'b0}};
            skid_r <= {DEC_W{1'b0}};
        end else begin
            if (load_main_in_s) begin
                main_r <= dec_in_s;
            end else if (load_main_skid_s) begin
                main_r <= skid_r;
            end else begin
                main_r <= main_r;
            end
            if (load_skid_s) begin
                skid_r <= dec_in_s;
            end else begin
                skid_r <= skid_r;
            end
        end
    end

    // Delivery counter; a delivery coinciding with flush still counts
    always_ff @(posedge clk) begin
        if (rst) begin
            count_r <= {CNT_W{1'b0}};
        end else if (deliver_s) begin
            count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            count_r <= count_r;
        end
    end

    assign op      = main_r.op;
    assign reg0    = main_r.reg0;
    assign reg1    = main_r.reg1;
    assign reg2    = main_r.reg2;
    assign addr    = main_r.addr;
    assign imm     = main_r.imm;
    assign illegal = main_r.illegal;
    assign count   = count_r;

endmodule : decode_pipe
